// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
// Holds the FSM state encoding, word size and counter-width arithmetic.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Counter holds latency-1, so clog2(max latency) bits suffice; never below 1 bit.
  function automatic int cnt_width(input int lat_a, input int lat_b);
    int m;
    int w;
    m = (lat_a > lat_b) ? lat_a : lat_b;
    w = clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port-style word store: synchronous write, registered synchronous read, no reset.
// Read data appears the cycle after re is sampled and holds until the next read.
module word_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the core's load/store port; response in cycle T+L+1.
// One request at a time: req_ready only in IDLE, stall holds the core until the RESP cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS   = 64,
  parameter logic [31:0] ADDR_BASE     = 32'h0000_0000,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int          IDX_W   = clog2(DEPTH_WORDS);
  localparam int          CW      = cnt_width(READ_LATENCY, WRITE_LATENCY);
  localparam logic [31:0] SPAN    = 32'(WORD_BYTES * DEPTH_WORDS);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              lat_we;
  logic              lat_fault;
  logic [IDX_W-1:0]  lat_idx;
  logic [31:0]       lat_wdata;

  logic [31:0]       offset;
  logic              req_fault;
  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  logic              commit;
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_rdata;

  // Offset wraps modulo 2^32, so addresses below the base land far out of range.
  assign offset    = req_addr - ADDR_BASE;
  assign req_fault = (req_addr[1:0] != 2'b00) || (offset >= SPAN);
  assign req_idx   = offset[IDX_W+1:2];

  assign accept = (state == IDLE) && req_valid;
  assign commit = (state == BUSY) && (cnt == '0);

  // Load data is fetched at acceptance so it is stable throughout BUSY, even for latency 1.
  assign ram_re = accept && !req_we && !reset;
  assign ram_we = commit && lat_we && !lat_fault && !reset;

  assign req_ready = (state == IDLE);
  assign stall     = accept || (state == BUSY);

  word_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (IDX_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (lat_idx),
    .wdata (lat_wdata),
    .re    (ram_re),
    .raddr (req_idx),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_fault <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid) begin
            lat_we    <= req_we;
            lat_fault <= req_fault;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
            cnt       <= req_we ? WR_LOAD : RD_LOAD;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= lat_fault;
            if (!lat_we) rsp_rdata <= lat_fault ? 32'h0 : ram_rdata;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default instance plus a base-0x1000, write-latency-3 instance.
// Outputs are sampled 1ns after the falling edge; inputs change on the falling edge.
module tb_dmem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, req_valid, req_we, req_ready, rsp_valid, rsp_err, stall;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        reset_b, req_valid_b, req_we_b, req_ready_b, rsp_valid_b, rsp_err_b, stall_b;
  logic [31:0] req_addr_b, req_wdata_b, rsp_rdata_b;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat;
  logic [31:0] rd;
  logic        er;

  dmem_responder dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .stall     (stall)
  );

  dmem_responder #(
    .DEPTH_WORDS   (64),
    .ADDR_BASE     (32'h0000_1000),
    .READ_LATENCY  (2),
    .WRITE_LATENCY (3)
  ) dut_b (
    .clock     (clock),
    .reset     (reset_b),
    .req_valid (req_valid_b),
    .req_we    (req_we_b),
    .req_addr  (req_addr_b),
    .req_wdata (req_wdata_b),
    .req_ready (req_ready_b),
    .rsp_valid (rsp_valid_b),
    .rsp_rdata (rsp_rdata_b),
    .rsp_err   (rsp_err_b),
    .stall     (stall_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s: observed no rsp_valid expected rsp_valid within 20 cycles", tag);
  endtask

  // One request on the default instance; lat counts falling edges from acceptance to rsp_valid.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit alter, output int l, output logic [31:0] rdata, output logic err);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    #1;
    chk1("ready_idle", req_ready, 1'b1);
    chk1("stall_req", stall, 1'b1);
    @(posedge clock);
    l = 0; rdata = 32'h0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (n == 1) begin
        req_valid = 1'b0;
        if (alter) begin
          req_addr  = addr ^ 32'h0000_000C;
          req_wdata = ~wdata;
        end
      end
      #1;
      if (rsp_valid) begin
        l = n;
        rdata = rsp_rdata;
        err = rsp_err;
        chk1("stall_resp", stall, 1'b0);
        chk1("ready_resp", req_ready, 1'b0);
        break;
      end
      chk1("stall_busy", stall, 1'b1);
      chk1("ready_busy", req_ready, 1'b0);
    end
    if (l == 0) timeout("rsp_timeout");
  endtask

  task automatic req_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int l, output logic [31:0] rdata, output logic err);
    @(negedge clock);
    req_valid_b = 1'b1; req_we_b = we; req_addr_b = addr; req_wdata_b = wdata;
    @(posedge clock);
    l = 0; rdata = 32'h0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (n == 1) req_valid_b = 1'b0;
      #1;
      if (rsp_valid_b) begin
        l = n; rdata = rsp_rdata_b; err = rsp_err_b;
        break;
      end
    end
    if (l == 0) timeout("rsp_timeout_b");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    reset_b = 1'b1; req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_b_rsp_valid", rsp_valid_b, 1'b0);
    chk1("rst_b_ready", req_ready_b, 1'b1);
    reset = 1'b0; reset_b = 1'b0;

    // Store then load.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, rd, er);
    chk("st10_lat", lat, 2); chk1("st10_err", er, 1'b0); chk("st10_rdata_kept", rd, 32'h0);
    do_req(1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er);
    chk("ld10_lat", lat, 3); chk1("ld10_err", er, 1'b0); chk("ld10_rdata", rd, 32'hDEADBEEF);

    // Misaligned store is suppressed and leaves rsp_rdata alone.
    do_req(1'b1, 32'h12, 32'h1, 1'b0, lat, rd, er);
    chk("mis_lat", lat, 2); chk1("mis_err", er, 1'b1); chk("mis_rdata_kept", rd, 32'hDEADBEEF);
    do_req(1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er);
    chk1("ld10b_err", er, 1'b0); chk("ld10b_rdata", rd, 32'hDEADBEEF);

    // Out-of-range load.
    do_req(1'b0, 32'h100, 32'h0, 1'b0, lat, rd, er);
    chk("oor_lat", lat, 3); chk1("oor_err", er, 1'b1); chk("oor_rdata", rd, 32'h0);

    // Back-to-back loads with req_valid held high.
    do_req(1'b1, 32'h14, 32'h12345678, 1'b0, lat, rd, er);
    chk1("st14_err", er, 1'b0);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clock);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clock);
      if (n == 1) req_addr = 32'h14;
      #1;
      case (n)
        3: begin
          chk1("b2b_rsp1_valid", rsp_valid, 1'b1);
          chk1("b2b_rsp1_ready", req_ready, 1'b0);
          chk("b2b_rsp1_rdata", rsp_rdata, 32'hDEADBEEF);
        end
        4: begin
          chk1("b2b_idle_ready", req_ready, 1'b1);
          chk1("b2b_idle_valid", rsp_valid, 1'b0);
          chk1("b2b_idle_stall", stall, 1'b1);
        end
        7: begin
          chk1("b2b_rsp2_valid", rsp_valid, 1'b1);
          chk("b2b_rsp2_rdata", rsp_rdata, 32'h12345678);
        end
        default: begin
          chk1("b2b_busy_ready", req_ready, 1'b0);
          chk1("b2b_busy_valid", rsp_valid, 1'b0);
        end
      endcase
    end
    req_valid = 1'b0;

    // Inputs altered during BUSY must not affect the latched store.
    do_req(1'b1, 32'h28, 32'h0, 1'b0, lat, rd, er);
    do_req(1'b1, 32'h24, 32'hAABBCCDD, 1'b1, lat, rd, er);
    chk1("alt_err", er, 1'b0);
    do_req(1'b0, 32'h24, 32'h0, 1'b0, lat, rd, er);
    chk("alt_ld24", rd, 32'hAABBCCDD);
    do_req(1'b0, 32'h28, 32'h0, 1'b0, lat, rd, er);
    chk("alt_ld28", rd, 32'h0);

    // Reset in the second BUSY cycle of a latency-3 store discards it.
    req_b(1'b1, 32'h1020, 32'h11111111, lat, rd, er);
    chk("b_st_lat", lat, 4); chk1("b_st_err", er, 1'b0);
    @(negedge clock);
    req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 32'h1020; req_wdata_b = 32'hCAFEF00D;
    @(posedge clock);
    @(negedge clock);
    req_valid_b = 1'b0;
    #1 chk1("b_busy1_stall", stall_b, 1'b1);
    @(negedge clock);
    reset_b = 1'b1;
    #1 chk1("b_busy2_stall", stall_b, 1'b1);
    @(negedge clock);
    reset_b = 1'b0;
    #1;
    chk1("b_post_rst_ready", req_ready_b, 1'b1);
    chk1("b_post_rst_valid", rsp_valid_b, 1'b0);
    chk1("b_post_rst_stall", stall_b, 1'b0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clock); #1;
      chk1("b_no_late_rsp", rsp_valid_b, 1'b0);
    end
    req_b(1'b0, 32'h1020, 32'h0, lat, rd, er);
    chk("b_ld_lat", lat, 3); chk1("b_ld_err", er, 1'b0); chk("b_ld_rdata", rd, 32'h11111111);

    // Address below the base wraps to a huge offset and faults.
    req_b(1'b0, 32'h0FFC, 32'h0, lat, rd, er);
    chk("b_wrap_lat", lat, 3); chk1("b_wrap_err", er, 1'b1); chk("b_wrap_rdata", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
